// File: rtl/id_ex_hazard_latch.sv
// rtl/id_ex_hazard_latch.sv - ID/EX pipeline register with load-use/freeze/flush hazard sequencing
module id_ex_hazard_latch #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      instr_ID,
    input  logic [31:0]      pc_ID,
    input  logic [31:0]      busA_ID,
    input  logic [31:0]      busB_ID,
    input  logic [31:0]      imm_ID,
    input  logic             valid_ID,
    input  logic             RegWr_ID,
    input  logic             memWr_ID,
    input  logic             memRd_ID,
    input  logic             memtoReg_ID,
    input  logic             flush_EX,
    input  logic             dmemAccess_MEM,
    input  logic             dhit,
    output logic [31:0]      instr_EX,
    output logic [31:0]      pc_EX,
    output logic [31:0]      busA_EX,
    output logic [31:0]      busB_EX,
    output logic [31:0]      imm_EX,
    output logic             RegWr_EX,
    output logic             memWr_EX,
    output logic             memRd_EX,
    output logic             memtoReg_EX,
    output logic             stall_ID,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] lu_count,
    output logic [CNT_W-1:0] frz_count
);

    // Opcode encodings shared with the decoder (MIPS primary opcodes)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FREEZE   = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_BUBBLE,
        ACT_HOLD
    } act_t;

    hz_state_t state_q;
    hz_state_t state_d;
    act_t      act;
    logic      stall;
    logic      lu_inc;
    logic      frz_inc;

    logic [5:0] opcode_ID;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic [4:0] rt_EX;
    logic       use_rs;
    logic       use_rt;
    logic       load_use;
    logic       freeze;

    assign opcode_ID = instr_ID[31:26];
    assign rs_ID     = instr_ID[25:21];
    assign rt_ID     = instr_ID[20:16];
    assign rt_EX     = instr_EX[20:16];

    // J/JAL/LUI do not read rs; only R-type, stores and branches read rt
    assign use_rs = (rs_ID == rt_EX) &&
                    !((opcode_ID == OP_J) || (opcode_ID == OP_JAL) || (opcode_ID == OP_LUI));
    assign use_rt = (rt_ID == rt_EX) &&
                    ((opcode_ID == OP_RTYPE) || (opcode_ID == OP_SW) ||
                     (opcode_ID == OP_BEQ)   || (opcode_ID == OP_BNE));

    // A load into r0 never produces a real dependency, so it is excluded
    assign load_use = memtoReg_EX & RegWr_EX & (rt_EX != 5'd0) & valid_ID & (use_rs | use_rt);
    assign freeze   = dmemAccess_MEM & ~dhit;

    // Priority resolution: freeze > flush > load-use > invalid > capture
    always_comb begin
        state_d = state_q;
        act     = ACT_CAPTURE;
        stall   = 1'b0;
        lu_inc  = 1'b0;
        frz_inc = 1'b0;
        if (freeze) begin
            act     = ACT_HOLD;
            stall   = 1'b1;
            state_d = ST_FREEZE;
            frz_inc = 1'b1;
        end else if (flush_EX) begin
            act     = ACT_BUBBLE;
            state_d = ST_RUN;
        end else if (load_use) begin
            act     = ACT_BUBBLE;
            stall   = 1'b1;
            state_d = ST_LU_STALL;
            lu_inc  = 1'b1;
        end else if (!valid_ID) begin
            act     = ACT_BUBBLE;
            state_d = ST_RUN;
        end else begin
            act     = ACT_CAPTURE;
            state_d = ST_RUN;
        end
    end

    assign stall_ID = stall & ~RST;
    assign hz_state = state_q;

    // Hazard state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ID/EX pipeline register: capture, insert bubble, or hold
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_EX    <= NOP_WORD;
            pc_EX       <= '0;
            busA_EX     <= '0;
            busB_EX     <= '0;
            imm_EX      <= '0;
            RegWr_EX    <= 1'b0;
            memWr_EX    <= 1'b0;
            memRd_EX    <= 1'b0;
            memtoReg_EX <= 1'b0;
        end else begin
            case (act)
                ACT_CAPTURE: begin
                    instr_EX    <= instr_ID;
                    pc_EX       <= pc_ID;
                    busA_EX     <= busA_ID;
                    busB_EX     <= busB_ID;
                    imm_EX      <= imm_ID;
                    RegWr_EX    <= RegWr_ID;
                    memWr_EX    <= memWr_ID;
                    memRd_EX    <= memRd_ID;
                    memtoReg_EX <= memtoReg_ID;
                end
                ACT_BUBBLE: begin
                    instr_EX    <= NOP_WORD;
                    pc_EX       <= '0;
                    busA_EX     <= '0;
                    busB_EX     <= '0;
                    imm_EX      <= '0;
                    RegWr_EX    <= 1'b0;
                    memWr_EX    <= 1'b0;
                    memRd_EX    <= 1'b0;
                    memtoReg_EX <= 1'b0;
                end
                default: begin
                    instr_EX    <= instr_EX;
                    pc_EX       <= pc_EX;
                    busA_EX     <= busA_EX;
                    busB_EX     <= busB_EX;
                    imm_EX      <= imm_EX;
                    RegWr_EX    <= RegWr_EX;
                    memWr_EX    <= memWr_EX;
                    memRd_EX    <= memRd_EX;
                    memtoReg_EX <= memtoReg_EX;
                end
            endcase
        end
    end

    // Saturating stall statistics; they stick at all-ones instead of wrapping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lu_count  <= '0;
            frz_count <= '0;
        end else begin
            if (lu_inc && (lu_count != {CNT_W{1'b1}})) begin
                lu_count <= lu_count + CNT_W'(1);
            end
            if (frz_inc && (frz_count != {CNT_W{1'b1}})) begin
                frz_count <= frz_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_latch.sv
// tb/tb_id_ex_hazard_latch.sv - directed self-checking bench for id_ex_hazard_latch
module tb_id_ex_hazard_latch;

    logic        CLK;
    logic        RST;
    logic [31:0] instr_ID, pc_ID, busA_ID, busB_ID, imm_ID;
    logic        valid_ID, RegWr_ID, memWr_ID, memRd_ID, memtoReg_ID;
    logic        flush_EX, dmemAccess_MEM, dhit;

    logic [31:0] instr_EX, pc_EX, busA_EX, busB_EX, imm_EX;
    logic        RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX, stall_ID;
    logic [1:0]  hz_state;
    logic [15:0] lu_count, frz_count;

    logic [31:0] s_instr_EX, s_pc_EX, s_busA_EX, s_busB_EX, s_imm_EX;
    logic        s_RegWr_EX, s_memWr_EX, s_memRd_EX, s_memtoReg_EX, s_stall_ID;
    logic [1:0]  s_hz_state;
    logic [1:0]  s_lu_count, s_frz_count;

    int tests;
    int failed;

    localparam logic [31:0] LW5  = 32'h8C25_0000; // lw  r5,0(r1)
    localparam logic [31:0] ADD5 = 32'h00A2_3020; // add r6,r5,r2
    localparam logic [31:0] LW0  = 32'h8C20_0004; // lw  r0,4(r1)
    localparam logic [31:0] ADD0 = 32'h0002_3020; // add r6,r0,r2

    id_ex_hazard_latch #(.CNT_W(16), .NOP_WORD(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST),
        .instr_ID(instr_ID), .pc_ID(pc_ID), .busA_ID(busA_ID), .busB_ID(busB_ID), .imm_ID(imm_ID),
        .valid_ID(valid_ID), .RegWr_ID(RegWr_ID), .memWr_ID(memWr_ID), .memRd_ID(memRd_ID),
        .memtoReg_ID(memtoReg_ID), .flush_EX(flush_EX), .dmemAccess_MEM(dmemAccess_MEM), .dhit(dhit),
        .instr_EX(instr_EX), .pc_EX(pc_EX), .busA_EX(busA_EX), .busB_EX(busB_EX), .imm_EX(imm_EX),
        .RegWr_EX(RegWr_EX), .memWr_EX(memWr_EX), .memRd_EX(memRd_EX), .memtoReg_EX(memtoReg_EX),
        .stall_ID(stall_ID), .hz_state(hz_state), .lu_count(lu_count), .frz_count(frz_count)
    );

    // Narrow-counter twin sharing all stimulus, used to reach saturation quickly
    id_ex_hazard_latch #(.CNT_W(2), .NOP_WORD(32'h0000_0000)) dut_small (
        .CLK(CLK), .RST(RST),
        .instr_ID(instr_ID), .pc_ID(pc_ID), .busA_ID(busA_ID), .busB_ID(busB_ID), .imm_ID(imm_ID),
        .valid_ID(valid_ID), .RegWr_ID(RegWr_ID), .memWr_ID(memWr_ID), .memRd_ID(memRd_ID),
        .memtoReg_ID(memtoReg_ID), .flush_EX(flush_EX), .dmemAccess_MEM(dmemAccess_MEM), .dhit(dhit),
        .instr_EX(s_instr_EX), .pc_EX(s_pc_EX), .busA_EX(s_busA_EX), .busB_EX(s_busB_EX), .imm_EX(s_imm_EX),
        .RegWr_EX(s_RegWr_EX), .memWr_EX(s_memWr_EX), .memRd_EX(s_memRd_EX), .memtoReg_EX(s_memtoReg_EX),
        .stall_ID(s_stall_ID), .hz_state(s_hz_state), .lu_count(s_lu_count), .frz_count(s_frz_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic v,
                         input logic rw, input logic mw, input logic mr, input logic m2r);
        instr_ID    = ins;
        pc_ID       = pc;
        busA_ID     = a;
        busB_ID     = b;
        imm_ID      = imm;
        valid_ID    = v;
        RegWr_ID    = rw;
        memWr_ID    = mw;
        memRd_ID    = mr;
        memtoReg_ID = m2r;
    endtask

    task automatic drive_load(input logic [31:0] ins, input logic [31:0] pc);
        drive(ins, pc, 32'h0000_1000, 32'h0, {16'h0, ins[15:0]}, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic drive_alu(input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b);
        drive(ins, pc, a, b, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tests          = 0;
        failed         = 0;
        RST            = 1'b1;
        flush_EX       = 1'b0;
        dmemAccess_MEM = 1'b0;
        dhit           = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_instr", instr_EX, 32'h0);
        check("rst_ctrl", {28'h0, RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX}, 32'h0);
        check("rst_hz", {30'h0, hz_state}, 32'h0);
        check("rst_lu", {16'h0, lu_count}, 32'h0);
        check("rst_frz", {16'h0, frz_count}, 32'h0);
        check("rst_stall", {31'h0, stall_ID}, 32'h0);
        check("rst_small_data", {31'h0, |{s_instr_EX, s_pc_EX, s_busA_EX, s_busB_EX, s_imm_EX,
              s_RegWr_EX, s_memWr_EX, s_memRd_EX, s_memtoReg_EX, s_stall_ID, s_hz_state}}, 32'h0);
        step();
        RST = 1'b0;

        // Load-use: lw r5 then add r6,r5,r2 costs exactly one bubble
        drive_load(LW5, 32'h40);
        step();
        check("t1_lw_instr", instr_EX, LW5);
        check("t1_lw_ctrl", {28'h0, RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX}, 32'hB);
        check("t1_lw_pc", pc_EX, 32'h40);
        drive_alu(ADD5, 32'h44, 32'h11, 32'h22);
        #1;
        check("t1_stall", {31'h0, stall_ID}, 32'h1);
        step();
        check("t1_bub_instr", instr_EX, 32'h0);
        check("t1_bub_ctrl", {28'h0, RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX}, 32'h0);
        check("t1_lu", {16'h0, lu_count}, 32'h1);
        check("t1_hz_lu", {30'h0, hz_state}, 32'h1);
        check("t1_stall_off", {31'h0, stall_ID}, 32'h0);
        step();
        check("t1_add_instr", instr_EX, ADD5);
        check("t1_add_busA", busA_EX, 32'h11);
        check("t1_add_busB", busB_EX, 32'h22);
        check("t1_hz_run", {30'h0, hz_state}, 32'h0);

        // Load into r0 is never a hazard
        drive_load(LW0, 32'h48);
        step();
        drive_alu(ADD0, 32'h4C, 32'h0, 32'h22);
        #1;
        check("t2_no_stall", {31'h0, stall_ID}, 32'h0);
        step();
        check("t2_add_instr", instr_EX, ADD0);
        check("t2_lu", {16'h0, lu_count}, 32'h1);

        // Three-cycle dcache miss freezes ID/EX
        drive_alu(ADD5, 32'h50, 32'h33, 32'h44);
        dmemAccess_MEM = 1'b1;
        dhit           = 1'b0;
        #1;
        check("t3_stall", {31'h0, stall_ID}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_instr", instr_EX, ADD0);
            check("t3_hold_busB", busB_EX, 32'h22);
            check("t3_hz_frz", {30'h0, hz_state}, 32'h2);
            check("t3_stall_hold", {31'h0, stall_ID}, 32'h1);
        end
        check("t3_frz", {16'h0, frz_count}, 32'h3);
        dhit = 1'b1;
        #1;
        check("t3_release_stall", {31'h0, stall_ID}, 32'h0);
        step();
        check("t3_rel_instr", instr_EX, ADD5);
        check("t3_rel_hz", {30'h0, hz_state}, 32'h0);
        check("t3_rel_frz", {16'h0, frz_count}, 32'h3);
        check("t3_small_frz", {30'h0, s_frz_count}, 32'h3);
        dmemAccess_MEM = 1'b0;
        dhit           = 1'b0;

        // Flush beats a coincident load-use
        drive_load(LW5, 32'h54);
        step();
        drive_alu(ADD5, 32'h58, 32'h1, 32'h2);
        flush_EX = 1'b1;
        #1;
        check("t4_stall", {31'h0, stall_ID}, 32'h0);
        step();
        check("t4_instr", instr_EX, 32'h0);
        check("t4_regwr", {31'h0, RegWr_EX}, 32'h0);
        check("t4_lu", {16'h0, lu_count}, 32'h1);
        check("t4_hz", {30'h0, hz_state}, 32'h0);
        flush_EX = 1'b0;
        step();
        check("t4_next_instr", instr_EX, ADD5);

        // Invalid IF/ID loads a bubble
        drive(ADD5, 32'h5C, 32'h7, 32'h8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("t5_stall", {31'h0, stall_ID}, 32'h0);
        step();
        check("t5_instr", instr_EX, 32'h0);
        check("t5_ctrl", {28'h0, RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX}, 32'h0);

        // Repeated load-use events: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive_load(LW5, 32'h60);
            step();
            drive_alu(ADD5, 32'h64, 32'h1, 32'h2);
            step();
            check("t6_lu", {16'h0, lu_count}, 32'(2 + i));
            check("t6_small_lu", {30'h0, s_lu_count}, (i >= 1) ? 32'h3 : 32'(2 + i));
        end

        // Leaving freeze is evaluated fresh: pending load-use takes the bubble
        drive_load(LW5, 32'h70);
        step();
        drive_alu(ADD5, 32'h74, 32'h5, 32'h6);
        dmemAccess_MEM = 1'b1;
        dhit           = 1'b0;
        step();
        step();
        check("t7_frz_hz", {30'h0, hz_state}, 32'h2);
        check("t7_frz_instr", instr_EX, LW5);
        check("t7_frz", {16'h0, frz_count}, 32'h5);
        check("t7_small_frz", {30'h0, s_frz_count}, 32'h3);
        check("t7_lu_held", {16'h0, lu_count}, 32'h6);
        dhit = 1'b1;
        #1;
        check("t7_lu_stall", {31'h0, stall_ID}, 32'h1);
        step();
        check("t7_lu_hz", {30'h0, hz_state}, 32'h1);
        check("t7_lu_instr", instr_EX, 32'h0);
        check("t7_lu", {16'h0, lu_count}, 32'h7);
        dmemAccess_MEM = 1'b0;
        dhit           = 1'b0;
        step();
        check("t7_add_instr", instr_EX, ADD5);
        check("t7_add_hz", {30'h0, hz_state}, 32'h0);

        // Asynchronous reset in the middle of a freeze
        drive_load(LW5, 32'h80);
        step();
        drive_alu(ADD5, 32'h84, 32'h9, 32'hA);
        dmemAccess_MEM = 1'b1;
        dhit           = 1'b0;
        step();
        check("t8_pre_hz", {30'h0, hz_state}, 32'h2);
        #2;
        RST = 1'b1;
        #1;
        check("t8_instr", instr_EX, 32'h0);
        check("t8_ctrl", {28'h0, RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX}, 32'h0);
        check("t8_lu", {16'h0, lu_count}, 32'h0);
        check("t8_frz", {16'h0, frz_count}, 32'h0);
        check("t8_hz", {30'h0, hz_state}, 32'h0);
        check("t8_stall", {31'h0, stall_ID}, 32'h0);
        check("t8_small_lu", {30'h0, s_lu_count}, 32'h0);
        RST            = 1'b0;
        dmemAccess_MEM = 1'b0;
        step();
        check("t8_post_instr", instr_EX, ADD5);
        check("t8_post_hz", {30'h0, hz_state}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_latch.md
Name: id_ex_hazard_latch

Overview:
- ID/EX pipeline register plus hazard sequencer for the 5-stage MIPS pipeline.
- Sits directly upstream of the EX-stage forwarding unit and produces instr_EX and the EX-stage control bits that flow on to EX/MEM and MEM/WB.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble for each.
- Freezes on data-cache misses, squashes on resolved branch/jump flushes, and keeps saturating stall statistics.

Parameters:
CNT_W, 16, width of each saturating performance counter
NOP_WORD, 32'h0000_0000, instruction word loaded as a bubble (sll r0,r0,0)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
instr_ID  input  32  decoded instruction word (word_t) from IF/ID
pc_ID  input  32  PC+4 of instr_ID
busA_ID, busB_ID  input  32 each  register-file read data
imm_ID  input  32  extended immediate
valid_ID  input  1  IF/ID holds a real instruction (ihit-qualified)
RegWr_ID, memWr_ID, memRd_ID, memtoReg_ID  input  1 each  decoder controls
flush_EX  input  1  branch/jump resolved taken; squash ID/EX
dmemAccess_MEM  input  1  MEM stage issuing a dcache read or write
dhit  input  1  dcache completes the MEM access this cycle
instr_EX, pc_EX, busA_EX, busB_EX, imm_EX  output  32 each  registered ID/EX contents
RegWr_EX, memWr_EX, memRd_EX, memtoReg_EX  output  1 each  registered controls
stall_ID  output  1  hold PC and IF/ID this cycle (combinational)
hz_state  output  2  0=RUN, 1=LU_STALL, 2=FREEZE
lu_count, frz_count  output  CNT_W each  load-use bubbles / frozen cycles

Behaviour:
- Reset (async): all data outputs 0, instr_EX=NOP_WORD, all controls 0, hz_state=RUN, counters 0. stall_ID is 0 while RST is high.
- Field decode: opcode [31:26], rs [25:21], rt [20:16]. Opcode codes come from cpu_types_pkg.
- freeze = dmemAccess_MEM & ~dhit.
- load_use = memtoReg_EX & RegWr_EX & (rt_EX != 0) & valid_ID & (useRs | useRt).
  - useRs: rs_ID == rt_EX and opcode_ID is not J, JAL or LUI.
  - useRt: rt_ID == rt_EX and opcode_ID is RTYPE, SW, BEQ or BNE.
- Per-edge priority, highest first:
  1. freeze: hold every ID/EX field. stall_ID=1. hz_state<=FREEZE. frz_count+1 (saturating).
  2. flush_EX: load bubble (NOP_WORD, all controls 0, data 0). stall_ID=0 (upstream redirects PC). A coincident load_use is ignored.
  3. load_use: load bubble. stall_ID=1. hz_state<=LU_STALL. lu_count+1 (saturating).
  4. ~valid_ID: load bubble. stall_ID=0.
  5. Otherwise: capture every *_ID input into *_EX. hz_state<=RUN.
- flush_EX is sampled only when not frozen. Upstream holds flush_EX asserted until it is consumed.
- Leaving FREEZE is not a return to a fixed state. The first edge with freeze=0 is evaluated fresh through rules 2-5 (a load_use there goes to LU_STALL).
- Load-use costs exactly one bubble. After the bubble, memtoReg_EX=0, so no re-detect occurs, and the dependent instruction latches on the next non-frozen edge.
- A bubble never asserts RegWr_EX, memWr_EX or memRd_EX. Bubbles therefore cannot trigger forwarding or memory side effects downstream.
- Counters saturate at all-ones and never wrap.
- RST asserted mid-freeze or mid-stall returns to reset values immediately. The first post-reset edge follows rules 1-5.

Test Plan:
- lw r5,0(r1) in EX with add r6,r5,r2 in ID (valid, no freeze) -> stall_ID=1 for one cycle; next edge instr_EX=0, RegWr_EX=0, lu_count=1; following edge instr_EX=add, hz_state=RUN.
- lw r0,4(r1) in EX with add r6,r0,r2 in ID -> no stall; add latches next edge; lu_count stays 0.
- dmemAccess_MEM=1, dhit=0 for 3 cycles, then dhit=1 -> ID/EX outputs unchanged for 3 edges; stall_ID=1 during those cycles; frz_count=3; hz_state=FREEZE, then RUN on the release edge.
- load_use and flush_EX both asserted, not frozen -> bubble loaded; stall_ID=0; lu_count unchanged.
- Preload lu_count=16'hFFFE, then 3 load-use events -> counter reads 16'hFFFF and stays there.
- Assert RST during FREEZE with valid data in ID/EX -> instr_EX=0, controls 0, counters 0, hz_state=RUN asynchronously, before any clock edge.
